// File: rtl/spi_adc_multi_read.sv
// Multi-channel serial ADC reader: one shared csn/sclk, one data line per ADC,
// delivers all channels of a conversion together with a frame sequence number.
module spi_adc_multi_read #(
  parameter int NCH   = 2,
  parameter int DW    = 12,
  parameter int LEAD  = 2,
  parameter int TRAIL = 2,
  parameter int HALF  = 1,
  parameter int QUIET = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic                adc_csn,
  output logic                adc_sclk,
  input  logic [NCH-1:0]      adc_sdata,
  output logic                out_valid,
  output logic [NCH*DW-1:0]   out_data,
  output logic [7:0]          out_seq
);

  localparam int FB   = LEAD + DW + TRAIL;
  localparam int BW   = $clog2(FB + 1);
  localparam int PMAX = (HALF > QUIET) ? HALF : QUIET;
  localparam int CW   = $clog2(PMAX + 1);

  localparam logic [CW-1:0] HALF_END  = CW'(HALF - 1);
  localparam logic [CW-1:0] QUIET_END = CW'(QUIET - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FB - 1);
  localparam logic [BW-1:0] KEEP_LO   = BW'(LEAD);
  localparam logic [BW-1:0] KEEP_HI   = BW'(LEAD + DW);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_LOW   = 3'd2;
  localparam logic [2:0] S_HIGH  = 3'd3;
  localparam logic [2:0] S_QUIET = 3'd4;

  logic [2:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_bit;
  logic [DW-1:0]     r_shift [NCH];
  logic              r_csn;
  logic              r_sclk;
  logic              r_valid;
  logic [NCH*DW-1:0] r_data;
  logic [7:0]        r_seq;
  logic [7:0]        r_frame;

  logic [2:0]        w_state_nxt;
  logic              w_phase_end;
  logic              w_sample;
  logic              w_keep;
  logic              w_deliver;
  logic              w_active_nxt;
  logic [NCH*DW-1:0] w_flat;

  assign w_phase_end = (r_state == S_QUIET) ? (r_cnt == QUIET_END) : (r_cnt == HALF_END);

  // The sampling edge is the one that ends LOW, i.e. the edge raising sclk.
  assign w_sample  = (r_state == S_LOW) && w_phase_end;
  assign w_keep    = w_sample && (r_bit >= KEEP_LO) && (r_bit < KEEP_HI);
  assign w_deliver = (r_state == S_HIGH) && w_phase_end && (r_bit == BIT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (en) w_state_nxt = S_SETUP;
      S_SETUP: if (w_phase_end) w_state_nxt = S_LOW;
      S_LOW:   if (w_phase_end) w_state_nxt = S_HIGH;
      S_HIGH:  if (w_phase_end) w_state_nxt = (r_bit == BIT_LAST) ? S_QUIET : S_LOW;
      S_QUIET: if (w_phase_end) w_state_nxt = en ? S_SETUP : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_active_nxt = (w_state_nxt == S_SETUP) || (w_state_nxt == S_LOW) ||
                        (w_state_nxt == S_HIGH);

  always_comb begin
    w_flat = '0;
    for (int i = 0; i < NCH; i++) begin
      w_flat[i*DW +: DW] = r_shift[i];
    end
  end

  // Pins are registered from the next state so csn/sclk are glitch-free and
  // always line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_csn   <= 1'b1;
      r_sclk  <= 1'b1;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_seq   <= '0;
      r_frame <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((w_state_nxt != r_state) || (r_state == S_IDLE)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_deliver) begin
        r_bit <= '0;
      end else if ((r_state == S_HIGH) && w_phase_end) begin
        r_bit <= r_bit + BW'(1);
      end
      r_csn   <= ~w_active_nxt;
      r_sclk  <= (w_state_nxt != S_LOW);
      r_valid <= w_deliver;
      if (w_deliver) begin
        r_data  <= w_flat;
        r_seq   <= r_frame;
        r_frame <= r_frame + 8'd1;
      end
    end
  end

  // Every kept position is rewritten each frame, so an aborted frame's
  // partial bits never reach out_data and this register needs no reset.
  always_ff @(posedge clk) begin
    if (w_keep) begin
      for (int i = 0; i < NCH; i++) begin
        r_shift[i] <= (r_shift[i] << 1) | DW'(adc_sdata[i]);
      end
    end
  end

  assign adc_csn   = r_csn;
  assign adc_sclk  = r_sclk;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_seq   = r_seq;

endmodule

// File: tb/tb_spi_adc_multi_read.sv
// Bench for spi_adc_multi_read: two instances (HALF=1 and HALF=3), behavioural
// ADC models that emit known frames, and a scoreboard of the words sent.
module tb_spi_adc_multi_read;
  localparam int DW = 12, LEAD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic en_a = 1'b0, en_b = 1'b0;
  logic csn_a, sclk_a, valid_a, csn_b, sclk_b, valid_b;
  logic [1:0] sdata_a = '0, sdata_b = '0;
  logic [23:0] data_a, data_b;
  logic [7:0] seq_a, seq_b;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;

  spi_adc_multi_read dut_a (
    .clk(clk), .rst(rst), .en(en_a), .adc_csn(csn_a), .adc_sclk(sclk_a),
    .adc_sdata(sdata_a), .out_valid(valid_a), .out_data(data_a), .out_seq(seq_a));

  spi_adc_multi_read #(.HALF(3)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .adc_csn(csn_b), .adc_sclk(sclk_b),
    .adc_sdata(sdata_b), .out_valid(valid_b), .out_data(data_b), .out_seq(seq_b));

  // ADC model A: new word per frame at csn fall, next bit on every sclk fall
  int fill_a = 2, force_req_a = 0, force_used_a = 0, wr_a = 0, bitn_a = 0;
  logic [23:0] force_word_a = '0, cur_a = '0;
  logic [23:0] expbuf_a [64];
  always @(negedge csn_a) begin
    if (force_used_a < force_req_a) begin cur_a = force_word_a; force_used_a++; end
    else cur_a = 24'($urandom);
    expbuf_a[wr_a % 64] = cur_a; wr_a++; bitn_a = 0;
  end
  always @(negedge sclk_a) if (csn_a === 1'b0) begin
    for (int c = 0; c < 2; c++) begin
      if (bitn_a < LEAD || bitn_a >= LEAD + DW) sdata_a[c] = (fill_a == 2) ? 1'($urandom) : 1'(fill_a);
      else sdata_a[c] = cur_a[c*DW + DW - 1 - (bitn_a - LEAD)];
    end
    bitn_a++;
  end

  // ADC model B
  int fill_b = 2, force_req_b = 0, force_used_b = 0, wr_b = 0, bitn_b = 0;
  logic [23:0] force_word_b = '0, cur_b = '0;
  logic [23:0] expbuf_b [64];
  always @(negedge csn_b) begin
    if (force_used_b < force_req_b) begin cur_b = force_word_b; force_used_b++; end
    else cur_b = 24'($urandom);
    expbuf_b[wr_b % 64] = cur_b; wr_b++; bitn_b = 0;
  end
  always @(negedge sclk_b) if (csn_b === 1'b0) begin
    for (int c = 0; c < 2; c++) begin
      if (bitn_b < LEAD || bitn_b >= LEAD + DW) sdata_b[c] = (fill_b == 2) ? 1'($urandom) : 1'(fill_b);
      else sdata_b[c] = cur_b[c*DW + DW - 1 - (bitn_b - LEAD)];
    end
    bitn_b++;
  end

  // Scoreboard/monitor A
  int rd_a = 0, exp_seq_a = 0, good_a = 0, bad_a = 0, vcnt_a = 0, dbl_a = 0, prot_a = 0;
  int last_vcyc_a = 0, prev_vcyc_a = 0, falls_a = 0, last_falls_a = 0, csnf_a = 0;
  logic prev_valid_a = 1'b0, prev_sclk_a = 1'b1, prev_csn_a = 1'b1;
  always begin
    @(negedge clk); #1;
    if (csn_a === 1'b1 && sclk_a === 1'b0) prot_a++;
    if (prev_valid_a === 1'b1 && valid_a === 1'b1) dbl_a++;
    if (prev_sclk_a === 1'b1 && sclk_a === 1'b0) falls_a++;
    if (prev_csn_a === 1'b1 && csn_a === 1'b0) csnf_a++;
    if (prev_csn_a === 1'b0 && csn_a === 1'b1) begin last_falls_a = falls_a; falls_a = 0; end
    if (rst) begin
      rd_a = wr_a; exp_seq_a = 0;
    end else if (valid_a === 1'b1) begin
      if (rd_a == wr_a) begin
        bad_a++; $display("FAIL a_unexpected_valid data=%h seq=%0d", data_a, seq_a);
      end else begin
        if (data_a !== expbuf_a[rd_a % 64] || seq_a !== 8'(exp_seq_a)) begin
          bad_a++;
          $display("FAIL a_frame got data=%h seq=%0d want data=%h seq=%0d",
                   data_a, seq_a, expbuf_a[rd_a % 64], exp_seq_a);
        end else good_a++;
        rd_a++;
      end
      exp_seq_a = (exp_seq_a + 1) % 256; vcnt_a++;
      prev_vcyc_a = last_vcyc_a; last_vcyc_a = cyc;
    end
    prev_valid_a = valid_a; prev_sclk_a = sclk_a; prev_csn_a = csn_a;
  end

  // Scoreboard/monitor B
  int rd_b = 0, exp_seq_b = 0, good_b = 0, bad_b = 0, vcnt_b = 0, prot_b = 0;
  int last_vcyc_b = 0, prev_vcyc_b = 0, lowrun_b = 0, last_low_b = 0, highrun_b = 0, last_high_b = 0;
  always begin
    @(negedge clk); #1;
    if (csn_b === 1'b1 && sclk_b === 1'b0) prot_b++;
    if (sclk_b === 1'b0) lowrun_b++;
    else if (lowrun_b > 0) begin last_low_b = lowrun_b; lowrun_b = 0; end
    if (csn_b === 1'b0 && sclk_b === 1'b1) highrun_b++;
    else if (highrun_b > 0) begin last_high_b = highrun_b; highrun_b = 0; end
    if (rst) begin
      rd_b = wr_b; exp_seq_b = 0;
    end else if (valid_b === 1'b1) begin
      if (rd_b == wr_b) begin
        bad_b++; $display("FAIL b_unexpected_valid data=%h seq=%0d", data_b, seq_b);
      end else begin
        if (data_b !== expbuf_b[rd_b % 64] || seq_b !== 8'(exp_seq_b)) begin
          bad_b++;
          $display("FAIL b_frame got data=%h seq=%0d want data=%h seq=%0d",
                   data_b, seq_b, expbuf_b[rd_b % 64], exp_seq_b);
        end else good_b++;
        rd_b++;
      end
      exp_seq_b = (exp_seq_b + 1) % 256; vcnt_b++;
      prev_vcyc_b = last_vcyc_b; last_vcyc_b = cyc;
    end
  end

  task automatic wait_vcnt_a(input int target, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #2;
      if (vcnt_a >= target) begin ok = 1; break; end
    end
  endtask

  task automatic wait_vcnt_b(input int target, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #2;
      if (vcnt_b >= target) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    n_checks++; if ({csn_a, sclk_a, valid_a} !== 3'b110) begin n_fail++;
      $display("FAIL reset_ctrl_a got=%b want=110", {csn_a, sclk_a, valid_a}); end
    n_checks++; if (data_a !== 24'd0 || seq_a !== 8'd0) begin n_fail++;
      $display("FAIL reset_data_a got data=%h seq=%0d want 0/0", data_a, seq_a); end
    n_checks++; if ({csn_b, sclk_b, valid_b, data_b, seq_b} !== {3'b110, 32'd0}) begin n_fail++;
      $display("FAIL reset_b got=%b %h %0d want 110/0/0", {csn_b, sclk_b, valid_b}, data_b, seq_b); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    bit ok; int v0, t1;
    fill_a = 0; force_word_a = 24'h123A5C; force_req_a++;
    v0 = vcnt_a; en_a = 1'b1;
    wait_vcnt_a(v0 + 1, 100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_first_valid timeout got=%0d want=%0d", vcnt_a, v0 + 1); end
    n_checks++; if (data_a !== 24'h123A5C) begin n_fail++; $display("FAIL basic_data got=%h want=123a5c", data_a); end
    n_checks++; if (seq_a !== 8'd0) begin n_fail++; $display("FAIL basic_seq got=%0d want=0", seq_a); end
    t1 = last_vcyc_a;
    wait_vcnt_a(v0 + 4, 200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_more_valid timeout got=%0d want=%0d", vcnt_a, v0 + 4); end
    n_checks++; if (last_vcyc_a - prev_vcyc_a !== 36) begin n_fail++;
      $display("FAIL basic_spacing got=%0d want=36", last_vcyc_a - prev_vcyc_a); end
    n_checks++; if (last_vcyc_a - t1 !== 108) begin n_fail++;
      $display("FAIL basic_3periods got=%0d want=108", last_vcyc_a - t1); end
    n_checks++; if (last_falls_a !== 16) begin n_fail++; $display("FAIL basic_sclk_pulses got=%0d want=16", last_falls_a); end
    en_a = 1'b0; fill_a = 2;
    repeat (80) @(negedge clk);
    #2;
    n_checks++; if ({csn_a, sclk_a} !== 2'b11) begin n_fail++; $display("FAIL basic_idle got=%b want=11", {csn_a, sclk_a}); end
  endtask

  task automatic test_half3;
    bit ok; int v0;
    fill_b = 0; force_word_b = 24'h123A5C; force_req_b++;
    v0 = vcnt_b; en_b = 1'b1;
    wait_vcnt_b(v0 + 1, 200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL half3_first_valid timeout got=%0d want=%0d", vcnt_b, v0 + 1); end
    n_checks++; if (data_b !== 24'h123A5C || seq_b !== 8'd0) begin n_fail++;
      $display("FAIL half3_data got=%h seq=%0d want=123a5c seq=0", data_b, seq_b); end
    wait_vcnt_b(v0 + 3, 400, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL half3_more_valid timeout got=%0d want=%0d", vcnt_b, v0 + 3); end
    n_checks++; if (last_vcyc_b - prev_vcyc_b !== 102) begin n_fail++;
      $display("FAIL half3_spacing got=%0d want=102", last_vcyc_b - prev_vcyc_b); end
    n_checks++; if (last_low_b !== 3) begin n_fail++; $display("FAIL half3_low_len got=%0d want=3", last_low_b); end
    n_checks++; if (last_high_b !== 3) begin n_fail++; $display("FAIL half3_high_len got=%0d want=3", last_high_b); end
    en_b = 1'b0; fill_b = 2;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_en_drop;
    bit ok; int v0, cf0, k, ks;
    v0 = vcnt_a; cf0 = csnf_a; en_a = 1'b1; ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #2;
      if (csn_a === 1'b0 && falls_a == 6) begin ok = 1; break; end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL endrop_reach_bit5 timeout got=%0d want=6", falls_a); end
    en_a = 1'b0;
    repeat (100) @(negedge clk);
    #2;
    n_checks++; if (vcnt_a !== v0 + 1) begin n_fail++; $display("FAIL endrop_pulses got=%0d want=%0d", vcnt_a, v0 + 1); end
    n_checks++; if (csnf_a !== cf0 + 1) begin n_fail++; $display("FAIL endrop_frames got=%0d want=%0d", csnf_a, cf0 + 1); end
    n_checks++; if ({csn_a, sclk_a} !== 2'b11) begin n_fail++; $display("FAIL endrop_idle got=%b want=11", {csn_a, sclk_a}); end
    en_a = 1'b1; k = 0; ks = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); #2;
      if (k == 0 && csn_a === 1'b0) k = i;
      if (sclk_a === 1'b0) begin ks = i; break; end
    end
    n_checks++; if (k !== 1) begin n_fail++; $display("FAIL endrop_restart_csn got=%0d want=1", k); end
    n_checks++; if (ks !== 2) begin n_fail++; $display("FAIL endrop_restart_sclk got=%0d want=2", ks); end
    en_a = 1'b0;
    wait_vcnt_a(v0 + 2, 60, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL endrop_restart_valid timeout got=%0d want=%0d", vcnt_a, v0 + 2); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit ok; int v0, k;
    v0 = vcnt_a; en_a = 1'b1; ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #2;
      if (csn_a === 1'b0 && falls_a == 8) begin ok = 1; break; end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_reach_bit7 timeout got=%0d want=8", falls_a); end
    rst = 1'b1;
    @(negedge clk); #2;
    n_checks++; if ({csn_a, sclk_a, valid_a} !== 3'b110) begin n_fail++;
      $display("FAIL rstmid_ctrl got=%b want=110", {csn_a, sclk_a, valid_a}); end
    n_checks++; if (data_a !== 24'd0 || seq_a !== 8'd0) begin n_fail++;
      $display("FAIL rstmid_data got data=%h seq=%0d want 0/0", data_a, seq_a); end
    n_checks++; if (vcnt_a !== v0) begin n_fail++; $display("FAIL rstmid_no_pulse got=%0d want=%0d", vcnt_a, v0); end
    rst = 1'b0; k = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk); #2;
      if (valid_a === 1'b1) begin k = i; break; end
    end
    n_checks++; if (k !== 34) begin n_fail++; $display("FAIL rstmid_full_frame_latency got=%0d want=34", k); end
    n_checks++; if (seq_a !== 8'd0) begin n_fail++; $display("FAIL rstmid_seq got=%0d want=0", seq_a); end
    en_a = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_discard;
    bit ok; int v0; logic [23:0] w;
    fill_a = 1; force_word_a = 24'h000000; force_req_a++;
    v0 = vcnt_a; en_a = 1'b1;
    wait_vcnt_a(v0 + 1, 100, ok);
    en_a = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL discard_valid timeout got=%0d want=%0d", vcnt_a, v0 + 1); end
    n_checks++; if (data_a !== 24'd0) begin n_fail++; $display("FAIL discard_zero got=%h want=000000", data_a); end
    repeat (5) @(negedge clk);
    w = 24'($urandom); force_word_a = w; force_req_a++;
    en_a = 1'b1;
    wait_vcnt_a(v0 + 2, 100, ok);
    en_a = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL discard_valid2 timeout got=%0d want=%0d", vcnt_a, v0 + 2); end
    n_checks++; if (data_a !== w) begin n_fail++; $display("FAIL discard_rand got=%h want=%h", data_a, w); end
    fill_a = 2;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_seq_wrap;
    bit ok; int v0, d0;
    rst = 1'b1; @(negedge clk); #2; rst = 1'b0;
    d0 = dbl_a; v0 = vcnt_a; en_a = 1'b1;
    for (int n = 0; n < 257; n++) begin
      wait_vcnt_a(v0 + n + 1, 60, ok);
      if (!ok) begin
        n_checks++; n_fail++;
        $display("FAIL wrap_valid timeout at frame %0d got=%0d", n, vcnt_a - v0);
        break;
      end
      n_checks++; if (seq_a !== 8'(n)) begin n_fail++; $display("FAIL wrap_seq got=%0d want=%0d", seq_a, n % 256); end
    end
    en_a = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    n_checks++; if (dbl_a !== d0) begin n_fail++; $display("FAIL wrap_double_valid got=%0d want=%0d", dbl_a, d0); end
  endtask

  task automatic test_scoreboard;
    n_checks++; if (bad_a !== 0 || good_a !== vcnt_a) begin n_fail++;
      $display("FAIL score_a got bad=%0d good=%0d want bad=0 good=%0d", bad_a, good_a, vcnt_a); end
    n_checks++; if (bad_b !== 0 || good_b !== vcnt_b) begin n_fail++;
      $display("FAIL score_b got bad=%0d good=%0d want bad=0 good=%0d", bad_b, good_b, vcnt_b); end
    n_checks++; if (prot_a !== 0 || prot_b !== 0) begin n_fail++;
      $display("FAIL sclk_low_with_csn_high got a=%0d b=%0d want 0/0", prot_a, prot_b); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_half3;
    test_en_drop;
    test_reset_mid;
    test_discard;
    test_seq_wrap;
    test_scoreboard;
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
